dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//   Shares the single data memory (dm) between two requesters: port 0 (CPU load/store path)
//   and port 1 (debug/loader or DMA engine). Issues at most one access per cycle.
//   Arbitration is round-robin, with an optional bounded lock for back-to-back bursts.
//   Read data returns registered, one cycle after the grant. Sits between sccpu/loader and dm.
// PARAMETERS
//   AW        32  address width
//   DW        32  data width
//   MAX_HOLD  8   max consecutive locked cycles before forced release (>=1)
//   CW        4   hold counter width; must satisfy 2^CW > MAX_HOLD
// PORTS
//   clk          in   1   system clock, rising edge
//   rstn         in   1   asynchronous active-low reset
//   req0/req1    in   1   access request, held until granted
//   we0/we1      in   1   1 = write, 0 = read
//   lock0/lock1  in   1   request to keep ownership after this grant
//   addr0/addr1  in   AW  byte address
//   wdata0/1     in   DW  write data
//   memop0/1     in   2   size code, passed through to dm memOp
//   gnt0/gnt1    out  1   combinational grant; the access occurs in this cycle
//   rvalid0/1    out  1   registered; rdata valid, one cycle after a read grant
//   rdata0/1     out  DW  registered read data
//   mem_we       out  1   to dm DMWr
//   mem_addr     out  AW  to dm addr
//   mem_din      out  DW  to dm din
//   mem_op       out  2   to dm memOp
//   mem_dout     in   DW  from dm dout (combinational read)
//   owner        out  2   debug status: 00 idle, 01 port0 locked, 10 port1 locked
// BEHAVIOUR
//   - Reset (rstn=0, async): state=IDLE, prio=0, hold_cnt=0, rvalid*=0, rdata*=0.
//     gnt*, mem_we and owner are forced 0 while rstn=0. A lock in progress is dropped.
//   - States
//     - IDLE: one requester -> grant it.
//       req0&req1 -> grant port prio; after that grant, prio <= ~winner.
//     - OWN0/OWN1: only the owner can be granted. The other port waits even if the owner is not requesting.
//   - IDLE->OWNx: granted port x has lockx=1. hold_cnt <= 1.
//   - OWNx: each cycle hold_cnt++. A grant is issued if reqx=1.
//   - OWNx->IDLE: lockx=0 in a granted cycle, or reqx=0, or hold_cnt==MAX_HOLD.
//     The forced-release cycle still grants x if reqx. prio <= ~x on exit.
//   - Forced release ignores lockx for the next IDLE arbitration.
//     The other port wins if it is requesting, so no starvation.
//   - At most one gnt high per cycle (one-hot or zero). gnt never rises without its req.
//   - Mux: mem_addr/mem_din/mem_op come from the granted port; mem_we = gnt & we.
//     No grant: mem_we=0, other mem_* hold port-0 values (don't care).
//   - Reads: on a read grant at edge t, rdata_x <= mem_dout and rvalid_x=1 for one cycle after t.
//     rdata holds its value after rvalid drops.
//   - Writes: dm commits at the grant edge. No rvalid.
//   - Back-to-back: a port may be granted every cycle. rvalid pulses each cycle accordingly.
//   - Write-then-read to the same address on consecutive grants returns the new data.
// TESTING
//   1. Reset: rstn=0 with req0=req1=1 -> gnt*=0, mem_we=0, rvalid*=0.
//      After release: port 0 granted first (prio=0).
//   2. Contention: req0=req1=1 reads held for 4 cycles -> gnt sequence 0,1,0,1.
//      rvalid alternates one cycle behind; rdata matches preloaded dm words.
//   3. Lock burst: port1 lock=1 writes 0x10,0x14,0x18, req0 pending -> gnt1 for 3 cycles, owner=10.
//      lock drop -> gnt0 next cycle.
//   4. Forced release: MAX_HOLD=8, port0 locked with continuous req, req1=1.
//      -> gnt0 for exactly 8 cycles, gnt1 in cycle 9.
//   5. Write/read: port0 writes 0xDEADBEEF to 0x20, then port1 reads 0x20.
//      -> rdata1=0xDEADBEEF with rvalid1 one cycle after gnt1.
//   6. Mid-burst reset: rstn=0 during OWN1 -> owner=00 immediately, rvalid cleared.
//      After release: IDLE, prio=0.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single data memory: round-robin between the CPU
// path (port 0) and the loader/DMA path (port 1), with a bounded ownership lock.
module dm_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_HOLD = 8,
   parameter int CW       = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic          lock0,
   input  logic          lock1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   input  logic [1:0]    memop0,
   input  logic [1:0]    memop1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic [1:0]    mem_op,
   input  logic [DW-1:0] mem_dout,
   output logic [1:0]    owner
);

   // Handshake: reqX is held until gntX; gntX is combinational and the memory access
   // happens in that same cycle. A read's data appears on rdataX with rvalidX one cycle later.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   localparam logic CAN_LOCK = (MAX_HOLD > 1);

   state_t        state_q, state_d;
   logic          prio_q, prio_d;
   logic          skip_q, skip_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;
   logic          g0, g1;
   logic          last_hold;
   logic          rvalid0_q, rvalid1_q;
   logic [DW-1:0] rdata0_q, rdata1_q;

   // The entry grant counts as the first locked cycle, so the MAX_HOLD-th grant releases.
   assign last_hold = (hold_cnt_q >= CW'(MAX_HOLD - 1));

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      skip_d     = skip_q;
      hold_cnt_d = hold_cnt_q;
      g0         = 1'b0;
      g1         = 1'b0;
      case (state_q)
         IDLE: begin
            skip_d = 1'b0;
            if (req0 && (!req1 || !prio_q)) g0 = 1'b1;
            else if (req1)                  g1 = 1'b1;
            if (req0 && req1) prio_d = g0;
            // skip_q marks a forced release; the released port is ~prio_q and may not relock now.
            if (g0 && lock0 && CAN_LOCK && !(skip_q && prio_q)) begin
               state_d    = OWN0;
               hold_cnt_d = CW'(1);
            end else if (g1 && lock1 && CAN_LOCK && !(skip_q && !prio_q)) begin
               state_d    = OWN1;
               hold_cnt_d = CW'(1);
            end
         end
         OWN0: begin
            g0         = req0;
            hold_cnt_d = hold_cnt_q + CW'(1);
            if (!req0 || !lock0 || last_hold) begin
               state_d    = IDLE;
               prio_d     = 1'b1;
               hold_cnt_d = '0;
               skip_d     = req0 && lock0 && last_hold;
            end
         end
         OWN1: begin
            g1         = req1;
            hold_cnt_d = hold_cnt_q + CW'(1);
            if (!req1 || !lock1 || last_hold) begin
               state_d    = IDLE;
               prio_d     = 1'b0;
               hold_cnt_d = '0;
               skip_d     = req1 && lock1 && last_hold;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt0     = g0 & rstn;
   assign gnt1     = g1 & rstn;
   assign owner    = state_q & {2{rstn}};
   assign mem_we   = (gnt0 & we0) | (gnt1 & we1);
   assign mem_addr = gnt1 ? addr1  : addr0;
   assign mem_din  = gnt1 ? wdata1 : wdata0;
   assign mem_op   = gnt1 ? memop1 : memop0;
   assign rvalid0  = rvalid0_q;
   assign rvalid1  = rvalid1_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         prio_q     <= 1'b0;
         skip_q     <= 1'b0;
         hold_cnt_q <= '0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         skip_q     <= skip_d;
         hold_cnt_q <= hold_cnt_d;
         rvalid0_q  <= gnt0 & ~we0;
         rvalid1_q  <= gnt1 & ~we1;
         if (gnt0 && !we0) rdata0_q <= mem_dout;
         if (gnt1 && !we1) rdata1_q <= mem_dout;
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a small dm stand-in, per-cycle expected records and
// read-data queues checked by a negedge monitor.
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req0, req1, we0, we1, lock0, lock1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [1:0]  memop0, memop1;
   logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
   logic [31:0] rdata0, rdata1, mem_addr, mem_din, mem_dout;
   logic [1:0]  mem_op, owner;

   logic [31:0] dm    [0:63];
   logic [31:0] model [0:63];
   logic [8:0]  exp_q [$];
   logic [31:0] rd0_q [$];
   logic [31:0] rd1_q [$];
   logic [1:0]  prev_rd;
   logic [8:0]  mon_e;
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   dm_arbiter #(.AW(32), .DW(32), .MAX_HOLD(8), .CW(4)) dut (
      .clk(clk), .rstn(rstn),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .memop0(memop0), .memop1(memop1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_op(mem_op), .mem_dout(mem_dout), .owner(owner)
   );

   // dm stand-in: combinational read, write at the grant edge
   assign mem_dout = dm[mem_addr[7:2]];
   always @(posedge clk) if (mem_we) dm[mem_addr[7:2]] <= mem_din;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle; eg = expected {gnt1,gnt0}, eo = expected owner.
   task automatic step(input logic r0, input logic w0, input logic l0,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [31:0] a1, input logic [31:0] d1,
                       input logic [1:0] eg, input logic [1:0] eo);
      req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
      exp_q.push_back({(eg[1] ? 2'b01 : 2'b10), ((eg[0] & w0) | (eg[1] & w1)), prev_rd, eo, eg});
      if (eg[0]) begin
         if (w0) model[a0[7:2]] = d0;
         else    rd0_q.push_back(model[a0[7:2]]);
      end
      if (eg[1]) begin
         if (w1) model[a1[7:2]] = d1;
         else    rd1_q.push_back(model[a1[7:2]]);
      end
      prev_rd = {eg[1] & ~w1, eg[0] & ~w0};
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("gnt",    {62'd0, gnt1, gnt0},       {55'd0, mon_e[1:0]});
         chk("owner",  {62'd0, owner},            {55'd0, mon_e[3:2]});
         chk("rvalid", {62'd0, rvalid1, rvalid0}, {55'd0, mon_e[5:4]});
         chk("mem_we", {63'd0, mem_we},           {55'd0, 1'b0, mon_e[6]});
         chk("mem_op", {62'd0, mem_op},           {55'd0, mon_e[8:7]});
      end
      if (rvalid0) begin
         if (rd0_q.size() > 0) chk("rdata0", {32'd0, rdata0}, {32'd0, rd0_q.pop_front()});
         else begin
            n_cmp++; n_fail++;
            $display("FAIL rvalid0_unexpected: got 1 expected 0 (t=%0t)", $time);
         end
      end
      if (rvalid1) begin
         if (rd1_q.size() > 0) chk("rdata1", {32'd0, rdata1}, {32'd0, rd1_q.pop_front()});
         else begin
            n_cmp++; n_fail++;
            $display("FAIL rvalid1_unexpected: got 1 expected 0 (t=%0t)", $time);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 64; i++) begin
         dm[i]    = 32'h1000_0000 + i;
         model[i] = 32'h1000_0000 + i;
      end
      prev_rd = 2'b00;
      memop0 = 2'b10; memop1 = 2'b01;
      rstn = 1'b0;
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b0; lock0 = 1'b1; lock1 = 1'b0;
      addr0 = 32'h0; addr1 = 32'h4; wdata0 = 32'h0; wdata1 = 32'h0;

      // reset holds everything quiet despite pending requests
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt0",    gnt0, 0);
      chk("rst_gnt1",    gnt1, 0);
      chk("rst_mem_we",  mem_we, 0);
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rvalid1", rvalid1, 0);
      chk("rst_owner",   owner, 0);
      chk("rst_rdata0",  rdata0, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // contention reads: 0,1,0,1
      step(1,0,0,32'h04,0, 1,0,0,32'h08,0, 2'b01, 2'b00);
      step(1,0,0,32'h0C,0, 1,0,0,32'h08,0, 2'b10, 2'b00);
      step(1,0,0,32'h0C,0, 1,0,0,32'h14,0, 2'b01, 2'b00);
      step(1,0,0,32'h18,0, 1,0,0,32'h14,0, 2'b10, 2'b00);
      step(0,0,0,32'h00,0, 0,0,0,32'h00,0, 2'b00, 2'b00);

      // port 1 locked write burst with port 0 pending
      step(0,0,0,32'h24,0, 1,1,1,32'h10,32'h1111_0010, 2'b10, 2'b00);
      step(1,0,0,32'h24,0, 1,1,1,32'h14,32'h1111_0014, 2'b10, 2'b10);
      step(1,0,0,32'h24,0, 1,1,0,32'h18,32'h1111_0018, 2'b10, 2'b10);
      step(1,0,0,32'h24,0, 0,0,0,32'h00,0,             2'b01, 2'b00);

      // forced release: 8 locked grants to port 0, then port 1
      step(1,0,1,32'h00,0, 1,0,0,32'h04,0, 2'b01, 2'b00);
      for (int i = 0; i < 7; i++)
         step(1,0,1,32'h00,0, 1,0,0,32'h04,0, 2'b01, 2'b01);
      step(1,0,1,32'h00,0, 1,0,0,32'h04,0, 2'b10, 2'b00);
      step(1,0,0,32'h00,0, 0,0,0,32'h00,0, 2'b01, 2'b00);

      // write then read across ports, then back-to-back reads of burst data
      step(1,1,0,32'h20,32'hDEAD_BEEF, 0,0,0,32'h00,0, 2'b01, 2'b00);
      step(0,0,0,32'h00,0,             1,0,0,32'h20,0, 2'b10, 2'b00);
      step(1,0,0,32'h14,0, 0,0,0,32'h00,0, 2'b01, 2'b00);
      step(1,0,0,32'h18,0, 0,0,0,32'h00,0, 2'b01, 2'b00);
      step(1,0,0,32'h10,0, 0,0,0,32'h00,0, 2'b01, 2'b00);

      // mid-burst reset during OWN1 with a read response in flight
      step(0,0,0,32'h00,0, 1,1,1,32'h30,32'h3333_0030, 2'b10, 2'b00);
      step(1,0,0,32'h00,0, 1,0,1,32'h08,0,             2'b10, 2'b10);
      chk("pre_rst_rvalid1", rvalid1, 1);
      chk("pre_rst_owner",   owner, 2'b10);
      if (rd1_q.size() > 0) chk("pre_rst_rdata1", rdata1, rd1_q.pop_front());
      rstn = 1'b0;
      #1;
      chk("mid_rst_owner",   owner, 0);
      chk("mid_rst_rvalid1", rvalid1, 0);
      chk("mid_rst_gnt1",    gnt1, 0);
      chk("mid_rst_gnt0",    gnt0, 0);
      prev_rd = 2'b00;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      step(1,0,0,32'h04,0, 1,0,0,32'h08,0, 2'b01, 2'b00);
      step(1,0,0,32'h04,0, 1,0,0,32'h08,0, 2'b10, 2'b00);
      step(0,0,0,32'h00,0, 0,0,0,32'h00,0, 2'b00, 2'b00);
      step(0,0,0,32'h00,0, 0,0,0,32'h00,0, 2'b00, 2'b00);
      @(negedge clk);

      chk("exp_q_drained", exp_q.size(), 0);
      chk("rd0_q_drained", rd0_q.size(), 0);
      chk("rd1_q_drained", rd1_q.size(), 0);
      chk("dm_0x30", dm[12], 32'h3333_0030);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
